// File: rtl/gol_iteration_counter.sv
// Generation counter for the Game of Life datapath: counts iterations while the
// run switch is on, with an optional prescaler, plus step/wrap marker pulses.
module gol_iteration_counter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             counter_clock_signal,
  input  logic             reset_n,
  input  logic             switch,
  output logic [WIDTH-1:0] counter,
  output logic             running,
  output logic             step,
  output logic             wrap
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic             sync1_q;
  logic             running_q;
  logic [15:0]      pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             inc_q, inc_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    inc_d   = 1'b0;
    if (running_q) begin
      if (pre_q == DIV_LAST) begin
        pre_d   = '0;
        count_d = count_q + 1'b1;
        inc_d   = 1'b1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
    // Markers trail the increment by one edge; a count of zero right after an
    // increment can only come from rolling over the all-ones value.
    step_d = inc_q;
    wrap_d = inc_q && (count_q == '0);
  end

  always_ff @(posedge counter_clock_signal or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      running_q <= 1'b0;
      pre_q     <= '0;
      count_q   <= '0;
      inc_q     <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync1_q   <= switch;
      running_q <= sync1_q;
      pre_q     <= pre_d;
      count_q   <= count_d;
      inc_q     <= inc_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = count_q;
  assign running = running_q;
  assign step    = step_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gol_iteration_counter.sv
// Scoreboard bench for gol_iteration_counter: a sample-history model predicts
// count/running/step/wrap; a negedge monitor compares against the DUT.
module tb_gol_iteration_counter;

  localparam int WIDTH = 8;
  localparam int DIV   = 1;
  localparam int DIV4  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;

  logic [WIDTH-1:0] counter, counter4;
  logic running, step, wrap;
  logic running4, step4, wrap4;

  always #10 clk = ~clk;

  gol_iteration_counter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .counter_clock_signal(clk),
    .reset_n             (rst_n),
    .switch              (sw),
    .counter             (counter),
    .running             (running),
    .step                (step),
    .wrap                (wrap)
  );

  gol_iteration_counter #(.WIDTH(WIDTH), .DIV(DIV4)) dut4 (
    .counter_clock_signal(clk),
    .reset_n             (rst_n),
    .switch              (sw),
    .counter             (counter4),
    .running             (running4),
    .step                (step4),
    .wrap                (wrap4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: switch samples per edge, enabled when the sample two
  // edges back was high; count = enabled edges / DIV modulo 2^WIDTH.
  typedef struct {
    int idx;
    int cnt;
    bit wr;
  } exp_t;

  int   hist[$];
  int   en_total = 0;
  int   edge_idx = 0;
  exp_t sbq[$];
  int   step4_seen = 0;
  int   wrap4_seen = 0;

  function automatic int model_count(input int divisor);
    return (en_total / divisor) % (1 << WIDTH);
  endfunction

  function automatic int model_running();
    if (hist.size() >= 2) return hist[hist.size()-2];
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        en_total = 0;
        sbq.delete();
      end else begin
        edge_idx++;
        hist.push_back(sw ? 1 : 0);
        if (hist.size() >= 3 && hist[hist.size()-3] == 1) begin
          en_total++;
          if (en_total % DIV == 0) begin
            exp_t e;
            e.idx = edge_idx;
            e.cnt = model_count(DIV);
            e.wr  = (e.cnt == 0);
            sbq.push_back(e);
          end
        end
        if (hist.size() > 8) void'(hist.pop_front());
      end
    end
  end

  // Monitor: pops the scoreboard whenever a step is due and compares.
  initial begin
    int   prev_cnt;
    bit   exp_step;
    exp_t e;
    prev_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cnt = 0;
      end else begin
        check("running", int'(running), model_running());
        check("running4", int'(running4), model_running());
        check("counter", int'(counter), model_count(DIV));
        while (sbq.size() > 0 && sbq[0].idx < edge_idx - 1) begin
          checks++;
          failures++;
          $display("FAIL step_missing actual=0 expected=1 for edge %0d @%0t", sbq[0].idx, $time);
          void'(sbq.pop_front());
        end
        exp_step = (sbq.size() > 0) && (sbq[0].idx == edge_idx - 1);
        check("step", int'(step), int'(exp_step));
        if (exp_step) begin
          e = sbq.pop_front();
          check("step_count", prev_cnt, e.cnt);
          check("wrap", int'(wrap), int'(e.wr));
        end else begin
          check("wrap_idle", int'(wrap), 0);
        end
        prev_cnt = int'(counter);
        if (step4) step4_seen++;
        if (wrap4) wrap4_seen++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_count(input int target, input string name);
    for (int i = 0; i < 400 && int'(counter) != target; i++) @(negedge clk);
    check(name, int'(counter), target);
  endtask

  initial begin
    int held;
    int wraps;
    int s4_before;

    // Reset held 3 clocks with switch high; first increment on the 3rd edge after release.
    sw = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_counter", int'(counter), 0);
      check("rst_running", int'(running), 0);
      check("rst_step", int'(step), 0);
      check("rst_wrap", int'(wrap), 0);
    end
    rst_n = 1'b1;
    @(negedge clk); check("rel_edge1", int'(counter), 0);
    @(negedge clk); check("rel_edge2", int'(counter), 0);
    @(negedge clk); check("rel_edge3", int'(counter), 1);

    // Run/pause timing pattern on a 20 ns clock.
    sw = 1'b0;
    do_reset();
    @(posedge clk);
    #5;
    #100; check("pause_hold", int'(counter), 0);
    sw = 1'b1; #50;
    sw = 1'b0; #50;
    check("pulse_incs", int'(counter), 2);
    sw = 1'b1; #500;
    check("run_500ns", int'(counter), 25);
    sw = 1'b0;
    repeat (3) @(negedge clk);
    check("run_tail", int'(counter), 27);

    // Wrap from 255 to 0.
    sw = 1'b1;
    wait_count(255, "reach_255");
    sw = 1'b0;
    @(negedge clk);
    check("wrap_to_zero", int'(counter), 0);
    wraps = 0;
    repeat (6) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        check("wrap_with_step", int'(step), 1);
      end
    end
    check("wrap_pulses", wraps, 1);

    // Asynchronous reset pulse mid-count.
    sw = 1'b1;
    wait_count(37, "reach_37");
    #2 rst_n = 1'b0;
    #1;
    check("async_clr", int'(counter), 0);
    check("async_running", int'(running), 0);
    check("async_step", int'(step), 0);
    #2 rst_n = 1'b1;
    @(negedge clk); check("resume_e1", int'(counter), 0);
    @(negedge clk); check("resume_e2", int'(counter), 0);
    @(negedge clk); check("resume_e3", int'(counter), 1);

    // Short switch glitch between edges is not seen.
    sw = 1'b0;
    repeat (4) @(negedge clk);
    held = model_count(DIV);
    #3 sw = 1'b1;
    #2 sw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("glitch_running", int'(running), 0);
    end
    check("glitch_count", int'(counter), held);

    // Prescaler DIV=4: 10 enabled clocks, pause 5, 2 more.
    do_reset();
    s4_before = step4_seen;
    @(negedge clk);
    sw = 1'b1;
    repeat (10) @(negedge clk);
    sw = 1'b0;
    repeat (4) @(negedge clk);
    check("div4_after10", int'(counter4), 2);
    @(negedge clk);
    check("div4_pause", int'(counter4), 2);
    sw = 1'b1;
    repeat (2) @(negedge clk);
    sw = 1'b0;
    repeat (4) @(negedge clk);
    check("div4_after12", int'(counter4), 3);
    check("div4_steps", step4_seen - s4_before, 3);
    check("div4_no_wrap", wrap4_seen, 0);

    // Randomized switch activity with occasional glitches and reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) sw = ~sw;
      if ($urandom_range(0, 29) == 0) begin
        #3 sw = ~sw;
        #2 sw = ~sw;
      end
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    sw = 1'b0;
    repeat (5) @(negedge clk);
    check("sb_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
